// File: rtl/onehot_sequencer.sv
// One-hot LED sequencer: registered decode of sel, or walking-one (up/down/bounce) paced by a prescaler.
// Define ONEHOT_BOUNCE_EN to make mode 3 bounce; otherwise mode 3 rotates up and has no direction state.
module onehot_sequencer #(
  parameter  int unsigned SEL_W = 3,
  parameter  int unsigned DIV_W = 16,
  localparam int unsigned OUT_W = 1 << SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [1:0]       mode,
  input  logic [SEL_W-1:0] sel,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic [OUT_W-1:0] onehot,
  output logic [SEL_W-1:0] index,
  output logic             wrap
);

  localparam logic [SEL_W-1:0] MAX_IDX = SEL_W'(OUT_W - 1);

  logic [SEL_W-1:0] index_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             wrap_d;
  logic             tick;
`ifdef ONEHOT_BOUNCE_EN
  logic             dir_q, dir_d;
`endif

  // State registers; onehot is kept as the decode of the index being loaded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index  <= '0;
      onehot <= OUT_W'(1);
      wrap   <= 1'b0;
      cnt_q  <= '0;
`ifdef ONEHOT_BOUNCE_EN
      dir_q  <= 1'b0;
`endif
    end else begin
      index  <= index_d;
      onehot <= OUT_W'(1) << index_d;
      wrap   <= wrap_d;
      cnt_q  <= cnt_d;
`ifdef ONEHOT_BOUNCE_EN
      dir_q  <= dir_d;
`endif
    end
  end

  // Next-state: load beats mode; >= lets a lowered div take effect promptly
  always_comb begin
    index_d = index;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    tick    = (cnt_q >= div);
`ifdef ONEHOT_BOUNCE_EN
    dir_d   = dir_q;
`endif
    if (ena) begin
      if (load) begin
        index_d = sel;
        cnt_d   = '0;
`ifdef ONEHOT_BOUNCE_EN
        dir_d   = 1'b0;
`endif
      end else if (mode == 2'd0) begin
        index_d = sel;
        cnt_d   = '0;
      end else if (!tick) begin
        cnt_d = cnt_q + DIV_W'(1);
      end else begin
        cnt_d = '0;
        case (mode)
          2'd2: begin
            wrap_d  = (index == '0);
            index_d = index - SEL_W'(1);
          end
`ifdef ONEHOT_BOUNCE_EN
          2'd3: begin
            if (!dir_q) begin
              if (index == MAX_IDX) begin
                dir_d   = 1'b1;
                index_d = MAX_IDX - SEL_W'(1);
                wrap_d  = 1'b1;
              end else begin
                index_d = index + SEL_W'(1);
              end
            end else begin
              if (index == '0) begin
                dir_d   = 1'b0;
                index_d = SEL_W'(1);
                wrap_d  = 1'b1;
              end else begin
                index_d = index - SEL_W'(1);
              end
            end
          end
`endif
          default: begin
            wrap_d  = (index == MAX_IDX);
            index_d = index + SEL_W'(1);
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_onehot_sequencer.sv
// Randomised self-checking bench for onehot_sequencer against a phase-based reference model.
// Honours ONEHOT_BOUNCE_EN the same way as the design.
module tb_onehot_sequencer;

  localparam int unsigned SEL_W = 3;
  localparam int unsigned DIV_W = 16;
  localparam int unsigned OUT_W = 1 << SEL_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ena;
  logic [1:0]       mode;
  logic [SEL_W-1:0] sel;
  logic             load;
  logic [DIV_W-1:0] div;
  logic [OUT_W-1:0] onehot;
  logic [SEL_W-1:0] index;
  logic             wrap;

  int vectors = 0;
  int errors  = 0;

  // Reference state: position, prescaler count, direction, last wrap
  int m_idx, m_cnt;
  bit m_dir, m_wrap;

  onehot_sequencer #(.SEL_W(SEL_W), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode), .sel(sel),
    .load(load), .div(div), .onehot(onehot), .index(index), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_idx = 0; m_cnt = 0; m_dir = 0; m_wrap = 0;
  endfunction

  // Bounce is a walk around a cycle of 2*OUT_W-2 phases folded onto the index range
  function automatic void bounce_step();
    int p, np, period;
    period = 2 * OUT_W - 2;
    p  = m_dir ? (period - m_idx) % period : m_idx;
    np = (p + 1) % period;
    m_wrap = (!m_dir && m_idx == OUT_W - 1) || (m_dir && m_idx == 0);
    m_dir  = (np >= OUT_W);
    m_idx  = (np < OUT_W) ? np : period - np;
  endfunction

  function automatic void model_clock();
    m_wrap = 0;
    if (!ena) return;
    if (load) begin
      m_idx = int'(sel); m_cnt = 0; m_dir = 0;
    end else if (mode == 2'd0) begin
      m_idx = int'(sel); m_cnt = 0;
    end else if (m_cnt >= int'(div)) begin
      m_cnt = 0;
      if (mode == 2'd2) begin
        m_wrap = (m_idx == 0);
        m_idx  = (m_idx + OUT_W - 1) % OUT_W;
      end else if (mode == 2'd3) begin
`ifdef ONEHOT_BOUNCE_EN
        bounce_step();
`else
        m_wrap = (m_idx == OUT_W - 1);
        m_idx  = (m_idx + 1) % OUT_W;
`endif
      end else begin
        m_wrap = (m_idx == OUT_W - 1);
        m_idx  = (m_idx + 1) % OUT_W;
      end
    end else begin
      m_cnt++;
    end
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ena = 1'b1; mode = 2'd0; sel = '0; load = 1'b0; div = '0;
    model_reset();
    #12;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [OUT_W-1:0] exp_oh;
    do_reset();
    #1;
    vectors++;
    if (onehot !== OUT_W'(1) || index !== '0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_initial: onehot=%h index=%0d wrap=%b want 01/0/0", onehot, index, wrap);
    end
    mode = 2'd1; div = DIV_W'(2);
    for (int i = 0; i < 7; i++) cycle();
    // Assert reset between edges; outputs must clear without a clock
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (onehot !== OUT_W'(1) || index !== '0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: onehot=%h index=%0d wrap=%b want 01/0/0", onehot, index, wrap);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // First step arrives div+1 edges after release
    for (int k = 1; k <= 6; k++) begin
      cycle();
      exp_oh = OUT_W'(1) << (k / 3);
      vectors++;
      if (onehot !== exp_oh || index !== SEL_W'(m_idx)) begin
        errors++;
        $display("FAIL reset_release k=%0d: onehot=%h want %h", k, onehot, exp_oh);
      end
    end
  endtask

  task automatic test_decode();
    logic [OUT_W-1:0] exp_oh;
    do_reset();
    mode = 2'd0; div = DIV_W'(0);
    for (int i = 0; i < int'(OUT_W); i++) begin
      sel = SEL_W'(i);
      cycle();
      exp_oh = OUT_W'(1) << i;
      vectors++;
      if (onehot !== exp_oh || index !== SEL_W'(i) || wrap !== 1'b0) begin
        errors++;
        $display("FAIL decode sel=%0d: onehot=%h index=%0d wrap=%b want %h", i, onehot, index, wrap, exp_oh);
      end
    end
    // Prescaler must have been held at 0: with div=0, rotate steps on the very next edge
    sel = SEL_W'(3); cycle();
    mode = 2'd1; cycle();
    vectors++;
    if (index !== SEL_W'(4)) begin
      errors++;
      $display("FAIL decode_cnt_held: index=%0d want 4", index);
    end
  endtask

  task automatic test_rotate_up();
    do_reset();
    mode = 2'd1; div = DIV_W'(2); sel = SEL_W'(6); load = 1'b1;
    cycle();
    load = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      cycle();
      vectors++;
      if (index !== SEL_W'(m_idx) || onehot !== (OUT_W'(1) << m_idx) || wrap !== m_wrap) begin
        errors++;
        $display("FAIL rotate_up k=%0d: index=%0d wrap=%b want %0d/%b", k, index, wrap, m_idx, m_wrap);
      end
    end
    // Load 2 with div=9, let cnt reach 5, then drop div below cnt
    sel = SEL_W'(2); div = DIV_W'(9); load = 1'b1;
    cycle();
    load = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    div = DIV_W'(2);
    cycle();
    vectors++;
    if (index !== SEL_W'(3) || onehot !== OUT_W'(8)) begin
      errors++;
      $display("FAIL div_lowered: index=%0d onehot=%h want 3/08", index, onehot);
    end
  endtask

  task automatic test_rotate_down();
    int exp_i;
    int hold_i;
    do_reset();
    mode = 2'd2; div = DIV_W'(0); sel = '0; load = 1'b1;
    cycle();
    load = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      exp_i = (OUT_W * 2 - k) % OUT_W;
      vectors++;
      if (index !== SEL_W'(exp_i) || wrap !== (k == 1 || k == 9)) begin
        errors++;
        $display("FAIL rotate_down k=%0d: index=%0d wrap=%b want %0d", k, index, wrap, exp_i);
      end
    end
    hold_i = int'(index);
    ena = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      vectors++;
      if (index !== SEL_W'(hold_i) || wrap !== 1'b0) begin
        errors++;
        $display("FAIL freeze k=%0d: index=%0d wrap=%b want %0d/0", k, index, wrap, hold_i);
      end
    end
    ena = 1'b1;
    cycle();
    vectors++;
    if (index !== SEL_W'((hold_i + OUT_W - 1) % OUT_W)) begin
      errors++;
      $display("FAIL unfreeze: index=%0d want %0d", index, (hold_i + OUT_W - 1) % OUT_W);
    end
  endtask

  task automatic test_bounce();
    int exp_i;
    bit exp_w;
    do_reset();
    mode = 2'd3; div = DIV_W'(0);
    for (int k = 1; k <= 20; k++) begin
      cycle();
`ifdef ONEHOT_BOUNCE_EN
      exp_i = k % (2 * OUT_W - 2);
      if (exp_i >= OUT_W) exp_i = 2 * OUT_W - 2 - exp_i;
      exp_w = (k % (2 * OUT_W - 2) == OUT_W) || (k % (2 * OUT_W - 2) == 1 && k > 1);
`else
      exp_i = k % OUT_W;
      exp_w = (exp_i == 0);
`endif
      vectors++;
      if (index !== SEL_W'(exp_i) || wrap !== exp_w) begin
        errors++;
        $display("FAIL bounce k=%0d: index=%0d wrap=%b want %0d/%b", k, index, wrap, exp_i, exp_w);
      end
    end
  endtask

  task automatic test_load_tick();
    do_reset();
    mode = 2'd1; div = DIV_W'(0);
    for (int i = 0; i < 3; i++) cycle();
    sel = SEL_W'(7 - $urandom_range(0, 6)); load = 1'b1;
    cycle();
    load = 1'b0;
    vectors++;
    if (index !== sel || wrap !== 1'b0) begin
      errors++;
      $display("FAIL load_tick: index=%0d wrap=%b want %0d/0", index, wrap, sel);
    end
    cycle();
    vectors++;
    if (index !== sel + SEL_W'(1)) begin
      errors++;
      $display("FAIL load_then_step: index=%0d want %0d", index, sel + SEL_W'(1));
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      ena  = ($urandom_range(0, 7) != 0);
      load = ($urandom_range(0, 11) == 0);
      sel  = SEL_W'($urandom_range(0, OUT_W - 1));
      if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) div = DIV_W'($urandom_range(0, 4));
      cycle();
      vectors++;
      if (index !== SEL_W'(m_idx) || onehot !== (OUT_W'(1) << m_idx) || wrap !== m_wrap) begin
        errors++;
        $display("FAIL random k=%0d: index=%0d onehot=%h wrap=%b want %0d/%b", k, index, onehot, wrap, m_idx, m_wrap);
      end
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_rotate_up();
    test_rotate_down();
    test_bounce();
    test_load_tick();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
